// File: rtl/fb_pkg.sv
// ============================================================================
// fb_pkg : shared constants, FSM state type and colour-bar table for the frame buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FRAME_PIX = 307200;
  localparam int PIX_W     = 12;

  typedef enum logic [1:0] {
    NO_FRAME = 2'd0,
    SWAP     = 2'd1,
    DISPLAY  = 2'd2
  } fb_state_t;

  localparam logic [PIX_W-1:0] BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_toggle_sync.sv
// ============================================================================
// cdc_toggle_sync : 2-FF synchroniser for a toggle signal, emits a 1-cycle pulse per edge
// Rev 1.0
// ============================================================================
`default_nettype none

module cdc_toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_async,
  output logic pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= tgl_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign pulse = r_sync ^ r_sync_d;

endmodule

`default_nettype wire

// File: rtl/frame_buf_reader.sv
// ============================================================================
// frame_buf_reader : read side of the double-buffered camera frame buffer feeding VGA
// Optional colour bars in NO_FRAME with FRAME_BUF_TEST_PATTERN_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module frame_buf_reader #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = fb_pkg::PIX_W,
  parameter int RD_LAT = 2
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              wr_done_tgl,
  input  logic              vs,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W:0]   mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              rd_bank,
  output logic              wr_bank,
  output logic              frame_valid,
  output logic [7:0]        drop_cnt
);

  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] c_frame_pix = ADDR_W'(H_RES * V_RES);

  fb_state_t         r_state;
  logic              r_vs;
  logic              r_pending;
  logic [RD_LAT:0]   r_vld;
  logic [RD_LAT:0]   r_nf;
  logic              w_done_pulse;
  logic              w_vs_fall;
  logic              w_swap_go;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_pix_part;
  logic [PIX_W-1:0]  w_nf_pix;

  cdc_toggle_sync u_done_sync (
    .clk       (vga_clk),
    .rst_n     (rst_n),
    .tgl_async (wr_done_tgl),
    .pulse     (w_done_pulse)
  );

  assign w_vs_fall  = r_vs & ~vs;
  assign w_swap_go  = w_vs_fall & r_pending & (r_state != SWAP);
  assign w_in_range = pix_addr < c_frame_pix;
  assign w_pix_part = w_in_range ? pix_addr : '0;

  // A done arriving on the cycle the swap is committed belongs to the next frame.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= NO_FRAME;
      r_vs        <= 1'b0;
      r_pending   <= 1'b0;
      rd_bank     <= 1'b0;
      wr_bank     <= 1'b1;
      frame_valid <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      r_vs <= vs;
      if (w_swap_go) begin
        r_pending <= w_done_pulse;
      end else if (w_done_pulse) begin
        r_pending <= 1'b1;
        if (r_pending && (drop_cnt != 8'hFF))
          drop_cnt <= drop_cnt + 8'd1;
      end
      case (r_state)
        NO_FRAME, DISPLAY: begin
          if (w_swap_go)
            r_state <= SWAP;
        end
        SWAP: begin
          rd_bank     <= ~rd_bank;
          wr_bank     <= rd_bank;
          frame_valid <= 1'b1;
          r_state     <= DISPLAY;
        end
        default: r_state <= NO_FRAME;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_addr <= '0;
      r_vld       <= '0;
      r_nf        <= '0;
      pix_data    <= '0;
    end else begin
      mem_rd_addr <= {rd_bank, w_pix_part};
      r_vld       <= {r_vld[RD_LAT-1:0], w_in_range};
      r_nf        <= {r_nf[RD_LAT-1:0], (r_state == NO_FRAME)};
      if (!r_vld[RD_LAT])
        pix_data <= '0;
      else if (r_nf[RD_LAT])
        pix_data <= w_nf_pix;
      else
        pix_data <= mem_rd_data;
    end
  end

`ifdef FRAME_BUF_TEST_PATTERN_EN
  logic [2:0] r_bar [RD_LAT+1];

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++)
        r_bar[i] <= 3'd0;
    end else begin
      r_bar[0] <= pix_addr[9:7];
      for (int i = 1; i <= RD_LAT; i++)
        r_bar[i] <= r_bar[i-1];
    end
  end

  assign w_nf_pix = PIX_W'(bar_colour(r_bar[RD_LAT]));
`else
  assign w_nf_pix = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_buf_reader.sv
// ============================================================================
// tb_frame_buf_reader : directed self-checking bench for frame_buf_reader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_buf_reader;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;
  localparam int RD_LAT = 2;

  logic              vga_clk     = 1'b0;
  logic              rst_n       = 1'b0;
  logic              wr_done_tgl = 1'b0;
  logic              vs          = 1'b1;
  logic [ADDR_W-1:0] pix_addr    = 19'd100;
  logic [ADDR_W:0]   mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data = '0;
  logic [PIX_W-1:0]  bram_s1     = '0;
  logic [PIX_W-1:0]  pix_data;
  logic              rd_bank;
  logic              wr_bank;
  logic              frame_valid;
  logic [7:0]        drop_cnt;
  logic [PIX_W-1:0]  exp_bar1;

  int checks = 0;
  int errors = 0;

  always #20 vga_clk = ~vga_clk;

  frame_buf_reader #(
    .H_RES  (640),
    .V_RES  (480),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .wr_done_tgl (wr_done_tgl),
    .vs          (vs),
    .pix_addr    (pix_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_data    (pix_data),
    .rd_bank     (rd_bank),
    .wr_bank     (wr_bank),
    .frame_valid (frame_valid),
    .drop_cnt    (drop_cnt)
  );

  // Two-stage BRAM model; every word but the two tagged ones is non-zero.
  function automatic logic [PIX_W-1:0] bram_word(input logic [ADDR_W:0] a);
    if (a == {1'b1, 19'd100}) return 12'hABC;
    if (a == {1'b0, 19'd100}) return 12'h123;
    return {a[ADDR_W], a[10:0]} | 12'h001;
  endfunction

  always @(posedge vga_clk) begin
    bram_s1     <= bram_word(mem_rd_addr);
    mem_rd_data <= bram_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic flip();
    @(negedge vga_clk);
    wr_done_tgl = ~wr_done_tgl;
  endtask

  task automatic vs_pulse();
    @(negedge vga_clk);
    vs = 1'b0;
    cyc(2);
    vs = 1'b1;
    cyc(3);
  endtask

  initial begin
`ifdef FRAME_BUF_TEST_PATTERN_EN
    exp_bar1 = 12'hFF0;
`else
    exp_bar1 = 12'h000;
`endif
    // Reset state
    cyc(3);
    chk("rst_pix_data",  32'(pix_data),    32'h0);
    chk("rst_addr",      32'(mem_rd_addr), 32'h0);
    chk("rst_rd_bank",   32'(rd_bank),     32'h0);
    chk("rst_wr_bank",   32'(wr_bank),     32'h1);
    chk("rst_fvalid",    32'(frame_valid), 32'h0);
    chk("rst_drop",      32'(drop_cnt),    32'h0);
    rst_n = 1'b1;

    // Two frames with no writer activity
    vs_pulse();
    cyc(20);
    vs_pulse();
    chk("nf_pix_data",   32'(pix_data),    32'h0);
    chk("nf_fvalid",     32'(frame_valid), 32'h0);
    chk("nf_rd_bank",    32'(rd_bank),     32'h0);
    chk("nf_wr_bank",    32'(wr_bank),     32'h1);
    chk("nf_addr",       32'(mem_rd_addr), 32'(20'h00064));

    // First frame: one done edge then vsync
    flip();
    cyc(5);
    pix_addr = 19'd307200;
    @(negedge vga_clk);
    vs = 1'b0;
    @(negedge vga_clk);
    chk("swap_cycle_bank", 32'(rd_bank), 32'h0);
    @(negedge vga_clk);
    chk("swap1_rd_bank", 32'(rd_bank),     32'h1);
    chk("swap1_wr_bank", 32'(wr_bank),     32'h0);
    chk("swap1_fvalid",  32'(frame_valid), 32'h1);
    vs = 1'b1;
    cyc(6);
    chk("oor_addr",      32'(mem_rd_addr), 32'(20'h80000));
    chk("oor_pix",       32'(pix_data),    32'h0);
    pix_addr = 19'd100;
    @(negedge vga_clk);
    chk("rd_addr_b1",    32'(mem_rd_addr), 32'(20'h80064));
    cyc(2);
    chk("lat_early",     32'(pix_data),    32'h0);
    @(negedge vga_clk);
    chk("lat_exact",     32'(pix_data),    32'hABC);
    pix_addr = 19'h7FFFF;
    @(negedge vga_clk);
    chk("max_addr",      32'(mem_rd_addr), 32'(20'h80000));
    cyc(2);
    chk("max_prev_pix",  32'(pix_data),    32'hABC);
    @(negedge vga_clk);
    chk("max_pix",       32'(pix_data),    32'h0);
    pix_addr = 19'd5000;
    cyc(4);
    chk("pix_5000",      32'(pix_data),    32'(bram_word({1'b1, 19'd5000})));

    // Three done edges in one frame: two drops, one swap
    pix_addr = 19'd100;
    flip();
    cyc(10);
    flip();
    cyc(10);
    flip();
    cyc(5);
    chk("drop_two",      32'(drop_cnt),    32'h2);
    chk("no_vs_no_swap", 32'(rd_bank),     32'h1);
    vs_pulse();
    chk("swap2_rd_bank", 32'(rd_bank),     32'h0);
    chk("swap2_wr_bank", 32'(wr_bank),     32'h1);
    vs_pulse();
    chk("pend_cleared",  32'(rd_bank),     32'h0);
    chk("drop_hold",     32'(drop_cnt),    32'h2);
    chk("pix_bank0",     32'(pix_data),    32'h123);

    // Done edge on the vs_fall cycle while already pending
    flip();
    cyc(5);
    flip();
    cyc(2);
    vs = 1'b0;
    cyc(2);
    chk("coinc_swap",    32'(rd_bank),     32'h1);
    vs = 1'b1;
    cyc(3);
    chk("coinc_nodrop",  32'(drop_cnt),    32'h2);
    vs_pulse();
    chk("coinc_swap2",   32'(rd_bank),     32'h0);
    vs_pulse();
    chk("coinc_done",    32'(rd_bank),     32'h0);

    // Asynchronous reset in the middle of a displayed line
    flip();
    cyc(5);
    vs_pulse();
    cyc(4);
    chk("pre_rst_pix",   32'(pix_data),    32'hABC);
    @(posedge vga_clk);
    #5;
    rst_n       = 1'b0;
    wr_done_tgl = 1'b0;
    #1;
    chk("arst_rd_bank",  32'(rd_bank),     32'h0);
    chk("arst_wr_bank",  32'(wr_bank),     32'h1);
    chk("arst_fvalid",   32'(frame_valid), 32'h0);
    chk("arst_drop",     32'(drop_cnt),    32'h0);
    chk("arst_pix",      32'(pix_data),    32'h0);
    chk("arst_addr",     32'(mem_rd_addr), 32'h0);
    @(negedge vga_clk);
    rst_n = 1'b1;
    vs_pulse();
    chk("post_rst_bank", 32'(rd_bank),     32'h0);
    chk("post_rst_fv",   32'(frame_valid), 32'h0);
    pix_addr = 19'h080;
    cyc(4);
    chk("bar1",          32'(pix_data),    32'(exp_bar1));
    pix_addr = 19'h380;
    cyc(4);
    chk("bar7",          32'(pix_data),    32'h0);
    pix_addr = 19'd307200;
    cyc(4);
    chk("bar_oor",       32'(pix_data),    32'h0);
    flip();
    cyc(5);
    vs_pulse();
    chk("post_rst_swap", 32'(rd_bank),     32'h1);
    chk("post_rst_fv1",  32'(frame_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
